// File: rtl/seven_seg_display_mux.sv
// Binary-to-BCD (sequential double dabble) front end feeding a
// time-multiplexed, active-low seven-segment scanner.
module seven_seg_display_mux #(
    parameter int NUM_DIGITS    = 4,
    parameter int VALUE_WIDTH   = 16,
    parameter int REFRESH_BITS  = 18,
    parameter int BLANK_LEADING = 1
) (
    input  logic                   clock_100Mhz,
    input  logic                   reset,
    input  logic [VALUE_WIDTH-1:0] value_in,
    input  logic                   value_load,
    input  logic [NUM_DIGITS-1:0]  dp_in,
    output logic                   busy,
    output logic                   overflow,
    output logic [NUM_DIGITS-1:0]  Anode_Activate,
    output logic [6:0]             LED_out,
    output logic                   dp_out
);

    localparam int BW = 4 * NUM_DIGITS;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CW = $clog2(VALUE_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

    state_t                  state;
    logic [VALUE_WIDTH-1:0]  shift;
    logic [BW-1:0]           bcd;
    logic [BW-1:0]           bcd_adj;
    logic [BW-1:0]           display;
    logic                    ovf_scratch;
    logic [CW-1:0]           bit_cnt;
    logic [REFRESH_BITS-1:0] prescaler;
    logic [IW-1:0]           index;

    logic [NUM_DIGITS-1:0]   blank;
    logic                    zero_run;
    logic [3:0]              cur_digit;
    logic                    cur_blank;
    logic                    cur_dp;
    logic [6:0]              seg_next;
    logic [NUM_DIGITS-1:0]   anode_next;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = 7'b0000001;
        endcase
        return s;
    endfunction

    always_comb begin
        bcd_adj = bcd;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (bcd[4*k +: 4] >= 4'd5)
                bcd_adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
        end
    end

    // Scratch registers are private to the engine; display and overflow
    // change only in COMMIT, so a conversion never shows partial results.
    always_ff @(posedge clock_100Mhz or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            overflow    <= 1'b0;
            display     <= '0;
            shift       <= '0;
            bcd         <= '0;
            ovf_scratch <= 1'b0;
            bit_cnt     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (value_load) begin
                        shift       <= value_in;
                        bcd         <= '0;
                        ovf_scratch <= 1'b0;
                        bit_cnt     <= CW'(VALUE_WIDTH);
                        busy        <= 1'b1;
                        state       <= CONVERT;
                    end
                end
                CONVERT: begin
                    bcd         <= {bcd_adj[BW-2:0], shift[VALUE_WIDTH-1]};
                    shift       <= shift << 1;
                    ovf_scratch <= ovf_scratch | bcd_adj[BW-1];
                    bit_cnt     <= bit_cnt - CW'(1);
                    if (bit_cnt == CW'(1))
                        state <= COMMIT;
                end
                COMMIT: begin
                    display  <= bcd;
                    overflow <= ovf_scratch;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock_100Mhz or negedge reset) begin
        if (!reset) begin
            prescaler <= '0;
            index     <= '0;
        end else begin
            prescaler <= prescaler + REFRESH_BITS'(1);
            if (&prescaler) begin
                if (index == IW'(NUM_DIGITS - 1))
                    index <= '0;
                else
                    index <= index + IW'(1);
            end
        end
    end

    // A digit blanks when it and every more significant digit are zero.
    always_comb begin
        zero_run = 1'b1;
        blank    = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run = zero_run && (display[4*k +: 4] == 4'd0);
            blank[k] = (BLANK_LEADING != 0) && (k > 0) && zero_run;
        end
    end

    always_comb begin
        cur_digit = 4'd0;
        cur_blank = 1'b0;
        cur_dp    = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (index == IW'(k)) begin
                cur_digit = display[4*k +: 4];
                cur_blank = blank[k];
                cur_dp    = dp_in[k];
            end
        end
        if (overflow)
            seg_next = 7'b1111110;
        else if (cur_blank)
            seg_next = 7'b1111111;
        else
            seg_next = seg7(cur_digit);
        anode_next = ~(NUM_DIGITS'(1) << index);
    end

    always_ff @(posedge clock_100Mhz or negedge reset) begin
        if (!reset) begin
            Anode_Activate <= ~NUM_DIGITS'(1);
            LED_out        <= 7'b0000001;
            dp_out         <= 1'b1;
        end else begin
            Anode_Activate <= anode_next;
            LED_out        <= seg_next;
            dp_out         <= ~cur_dp;
        end
    end

endmodule

// File: tb/tb_seven_seg_display_mux.sv
// Directed bench: three builds (4-digit blanking, 4-digit no blanking,
// 3-digit) share clock, reset and load inputs.
module tb_seven_seg_display_mux;

    logic        clk;
    logic        reset;
    logic [15:0] value_in;
    logic        value_load;
    logic [3:0]  dp_in;

    logic        busy_a, ovf_a, dpo_a;
    logic [3:0]  an_a;
    logic [6:0]  led_a;
    logic        busy_b, ovf_b, dpo_b;
    logic [3:0]  an_b;
    logic [6:0]  led_b;
    logic        busy_c, ovf_c, dpo_c;
    logic [2:0]  an_c;
    logic [6:0]  led_c;

    int total = 0;
    int bad   = 0;

    seven_seg_display_mux #(
        .NUM_DIGITS(4), .VALUE_WIDTH(16),
        .REFRESH_BITS(2), .BLANK_LEADING(1)
    ) dut_a (
        .clock_100Mhz(clk), .reset(reset),
        .value_in(value_in), .value_load(value_load),
        .dp_in(dp_in), .busy(busy_a), .overflow(ovf_a),
        .Anode_Activate(an_a), .LED_out(led_a), .dp_out(dpo_a)
    );

    seven_seg_display_mux #(
        .NUM_DIGITS(4), .VALUE_WIDTH(16),
        .REFRESH_BITS(2), .BLANK_LEADING(0)
    ) dut_b (
        .clock_100Mhz(clk), .reset(reset),
        .value_in(value_in), .value_load(value_load),
        .dp_in(dp_in), .busy(busy_b), .overflow(ovf_b),
        .Anode_Activate(an_b), .LED_out(led_b), .dp_out(dpo_b)
    );

    seven_seg_display_mux #(
        .NUM_DIGITS(3), .VALUE_WIDTH(16),
        .REFRESH_BITS(2), .BLANK_LEADING(1)
    ) dut_c (
        .clock_100Mhz(clk), .reset(reset),
        .value_in(value_in), .value_load(value_load),
        .dp_in(dp_in[2:0]), .busy(busy_c), .overflow(ovf_c),
        .Anode_Activate(an_c), .LED_out(led_c), .dp_out(dpo_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_an(input int which, input int k, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64 && !ok; i++) begin
            case (which)
                0:       ok = (an_a == ~(4'b0001 << k));
                1:       ok = (an_b == ~(4'b0001 << k));
                default: ok = (an_c == ~(3'b001 << k));
            endcase
            if (!ok) tick();
        end
    endtask

    task automatic load(input logic [15:0] v);
        value_in   = v;
        value_load = 1'b1;
        tick();
        value_load = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            ok = !busy_a;
            if (!ok) tick();
        end
    endtask

    task automatic test_reset();
        bit ok;
        reset = 1'b0;
        tick();
        tick();
        total++;
        if (busy_a !== 1'b0) begin
            bad++; $display("FAIL rst_busy got=%b want=0", busy_a);
        end
        total++;
        if (ovf_a !== 1'b0) begin
            bad++; $display("FAIL rst_ovf got=%b want=0", ovf_a);
        end
        total++;
        if (an_a !== 4'b1110) begin
            bad++; $display("FAIL rst_anode got=%b want=1110", an_a);
        end
        total++;
        if (led_a !== 7'b0000001) begin
            bad++; $display("FAIL rst_led got=%b want=0000001", led_a);
        end
        total++;
        if (dpo_a !== 1'b1) begin
            bad++; $display("FAIL rst_dp got=%b want=1", dpo_a);
        end
        reset = 1'b1;
        for (int k = 1; k < 4; k++) begin
            wait_an(0, k, ok);
            total++;
            if (!ok || led_a !== 7'b1111111) begin
                bad++;
                $display("FAIL rst_blank d%0d got=%b want=1111111", k, led_a);
            end
        end
    endtask

    task automatic test_convert_1234();
        bit ok;
        int n;
        logic [6:0] exp_seg [4];
        exp_seg = '{7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111};
        load(16'd1234);
        total++;
        if (busy_a !== 1'b1) begin
            bad++; $display("FAIL busy_rise got=%b want=1", busy_a);
        end
        n = 0;
        while (busy_a && n < 100) begin
            n++;
            tick();
        end
        total++;
        if (n != 17) begin
            bad++; $display("FAIL busy_len got=%0d want=17", n);
        end
        for (int k = 0; k < 4; k++) begin
            wait_an(0, k, ok);
            total++;
            if (!ok || led_a !== exp_seg[k]) begin
                bad++;
                $display("FAIL d1234 d%0d got=%b want=%b",
                         k, led_a, exp_seg[k]);
            end
        end
        wait_an(0, 1, ok);
        wait_an(0, 0, ok);
        n = 0;
        while (an_a == 4'b1110 && n < 20) begin
            n++;
            tick();
        end
        total++;
        if (n != 4) begin
            bad++; $display("FAIL dwell got=%0d want=4", n);
        end
    endtask

    task automatic test_blank();
        bit ok;
        load(16'd7);
        wait_idle(ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL blank_idle got=busy want=idle");
        end
        wait_an(0, 0, ok);
        total++;
        if (!ok || led_a !== 7'b0001111) begin
            bad++; $display("FAIL blank_d0 got=%b want=0001111", led_a);
        end
        for (int k = 1; k < 4; k++) begin
            wait_an(0, k, ok);
            total++;
            if (!ok || led_a !== 7'b1111111) begin
                bad++;
                $display("FAIL blank_on d%0d got=%b want=1111111", k, led_a);
            end
            wait_an(1, k, ok);
            total++;
            if (!ok || led_b !== 7'b0000001) begin
                bad++;
                $display("FAIL blank_off d%0d got=%b want=0000001", k, led_b);
            end
        end
    endtask

    task automatic test_dp();
        bit ok;
        dp_in = 4'b0100;
        wait_an(0, 2, ok);
        total++;
        if (!ok || dpo_a !== 1'b0) begin
            bad++; $display("FAIL dp_lit got=%b want=0", dpo_a);
        end
        wait_an(0, 1, ok);
        total++;
        if (!ok || dpo_a !== 1'b1) begin
            bad++; $display("FAIL dp_dark got=%b want=1", dpo_a);
        end
        dp_in = 4'b0000;
    endtask

    task automatic test_overflow();
        bit ok;
        load(16'd10000);
        wait_idle(ok);
        total++;
        if (!ok || ovf_a !== 1'b1) begin
            bad++; $display("FAIL ovf_set got=%b want=1", ovf_a);
        end
        for (int k = 0; k < 4; k++) begin
            wait_an(0, k, ok);
            total++;
            if (!ok || led_a !== 7'b1111110) begin
                bad++;
                $display("FAIL ovf_dash d%0d got=%b want=1111110", k, led_a);
            end
        end
        load(16'd9999);
        wait_idle(ok);
        total++;
        if (!ok || ovf_a !== 1'b0) begin
            bad++; $display("FAIL ovf_clr got=%b want=0", ovf_a);
        end
        for (int k = 0; k < 4; k++) begin
            wait_an(0, k, ok);
            total++;
            if (!ok || led_a !== 7'b0000100) begin
                bad++;
                $display("FAIL d9999 d%0d got=%b want=0000100", k, led_a);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        bit prev;
        int falls;
        logic [6:0] exp_seg [4];
        exp_seg = '{7'b0010010, 7'b1001100, 7'b1111111, 7'b1111111};
        value_in   = 16'd42;
        value_load = 1'b1;
        tick();
        value_in   = 16'd99;
        tick();
        value_load = 1'b0;
        falls = 0;
        prev  = busy_a;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (prev && !busy_a) falls++;
            prev = busy_a;
        end
        total++;
        if (falls != 1) begin
            bad++; $display("FAIL b2b_falls got=%0d want=1", falls);
        end
        for (int k = 0; k < 4; k++) begin
            wait_an(0, k, ok);
            total++;
            if (!ok || led_a !== exp_seg[k]) begin
                bad++;
                $display("FAIL b2b d%0d got=%b want=%b", k, led_a, exp_seg[k]);
            end
        end
    endtask

    task automatic test_reset_abort();
        bit ok;
        load(16'd500);
        repeat (4) tick();
        #2;
        reset = 1'b0;
        #1;
        total++;
        if (busy_a !== 1'b0) begin
            bad++; $display("FAIL abort_busy got=%b want=0", busy_a);
        end
        total++;
        if (an_a !== 4'b1110 || led_a !== 7'b0000001) begin
            bad++;
            $display("FAIL abort_out got=%b/%b want=1110/0000001", an_a, led_a);
        end
        tick();
        reset = 1'b1;
        for (int k = 1; k < 4; k++) begin
            wait_an(0, k, ok);
            total++;
            if (!ok || led_a !== 7'b1111111) begin
                bad++;
                $display("FAIL abort_d%0d got=%b want=1111111", k, led_a);
            end
        end
        wait_an(0, 0, ok);
        total++;
        if (!ok || led_a !== 7'b0000001 || busy_a !== 1'b0) begin
            bad++;
            $display("FAIL abort_d0 got=%b busy=%b want=0000001 busy=0",
                     led_a, busy_a);
        end
    endtask

    task automatic test_three_digits();
        int m;
        logic [2:0] prev;
        logic [2:0] seen [3];
        logic [2:0] exp3 [3];
        exp3 = '{3'b101, 3'b011, 3'b110};
        seen = '{3'b000, 3'b000, 3'b000};
        reset = 1'b0;
        tick();
        reset = 1'b1;
        total++;
        if (an_c !== 3'b110) begin
            bad++; $display("FAIL nd3_start got=%b want=110", an_c);
        end
        m    = 0;
        prev = an_c;
        for (int i = 0; i < 60 && m < 3; i++) begin
            tick();
            if (an_c != prev) begin
                seen[m] = an_c;
                m++;
                prev = an_c;
            end
        end
        for (int j = 0; j < 3; j++) begin
            total++;
            if (seen[j] !== exp3[j]) begin
                bad++;
                $display("FAIL nd3_seq %0d got=%b want=%b", j, seen[j], exp3[j]);
            end
        end
    endtask

    initial begin
        reset      = 1'b0;
        value_in   = 16'd0;
        value_load = 1'b0;
        dp_in      = 4'b0000;
        test_reset();
        test_convert_1234();
        test_blank();
        test_dp();
        test_overflow();
        test_back_to_back();
        test_reset_abort();
        test_three_digits();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
